kd_sort_sched: RTL and testbench
================================

# kd_sort_sched

Root-side scheduler for the kd-tree sort pass of the k-means engine. On a `start` pulse it walks the tree level by level. For each level it drives the root node's command port with a two-beat `configure_sort` (time-to-live, sorting axis), then `start_sort`, then waits for `send_sort_ack` to return up the tree. It sits between the k-means top-level control and the root `node` of the kd-tree, and is the only master of the root's top-side command/data port.

## Interface
- `DIM`, 3: number of point axes; the axis cycles 0..DIM-1.
- `DEPTH`, 4: tree levels to sort, ≥1.
- `CMD_W`, 4: command field width.
- `DATA_W`, 16: data field width.
- `TIMEOUT`, 1024: max cycles in WAIT_ACK before abort, ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request for a full sort pass; ignored while `busy`.
- `busy` out 1: high from the cycle after `start` is accepted until the pass ends.
- `done` out 1: one-cycle pulse, pass completed.
- `error` out 1: one-cycle pulse, ack timeout.
- `level` out clog2(DEPTH)+1: level currently being sorted.
- `cmd_to_root` out CMD_W: command beat.
- `data_to_root` out DATA_W: data beat.
- `cmd_valid` out 1: beat valid.
- `cmd_ready` in 1: root accepts beat when `cmd_valid && cmd_ready`.
- `cmd_from_root` in CMD_W: upward command.
- `cmd_from_root_valid` in 1: upward command valid.

## Operation
- States: IDLE, CFG_TTL, CFG_AXIS, START, WAIT_ACK.
- **IDLE**
  - On `start`: set `level`=0 and axis=0, go to CFG_TTL.
- **CFG_TTL**
  - Drive `configure_sort` with data = `level` (zero-extended). A node at depth d decrements on forwarding and sorts when TTL reaches 0.
  - Go to CFG_AXIS on handshake.
- **CFG_AXIS**
  - Drive `configure_sort` with data = axis.
  - Go to START on handshake.
- **START**
  - Drive `start_sort`, data 0.
  - Go to WAIT_ACK on handshake. Clear the timeout counter.
- **WAIT_ACK**
  - `cmd_valid`=0. The timeout counter increments each cycle.
  - On `cmd_from_root_valid && cmd_from_root==send_sort_ack`:
    - If `level`==DEPTH-1: pulse `done` next cycle and go to IDLE.
    - Otherwise: increment `level`, advance axis (wrapping at DIM-1 → 0), and go to CFG_TTL.
  - Any other upward command is ignored.
  - If the counter reaches TIMEOUT-1 without an ack: pulse `error`, go to IDLE.
  - An ack in the same cycle as the timeout wins; no `error`.
- Upward commands outside WAIT_ACK are ignored.
- Axis is a wrapping counter; no modulo hardware.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `level`=0, `cmd_valid`=0, `cmd_to_root`=nop, `data_to_root`=0, state IDLE, counters 0.
- `rst` mid-pass aborts without `done`/`error`. Outputs reach reset values on the cycle after `rst` is sampled.
- `start` sampled at cycle t gives `busy`=1 and the first `cmd_valid` at t+1.
- While `cmd_valid`=1 and `cmd_ready`=0, `cmd_to_root` and `data_to_root` hold stable. No beat is dropped or repeated.
- With `cmd_ready` tied high, each level takes 3 beat cycles plus the ack wait. The next level's first beat comes the cycle after the ack is sampled.
- `done` or `error` is asserted in the cycle `busy` falls. A new `start` is accepted in that same cycle.
- All outputs are registered.

## Structure
- Shared package `kd_pkg`:
  - Command encodings: nop=0, start_sort=1, configure_sort=2, wait_sort_ack=3, send_sort_ack=4, switch_with_top=5, switch_with_down=6.
  - State enum.
  - CMD_W default.
- `node` uses the same package.
- Single module. No sub-module is warranted; the timeout counter stays inline.

## Test plan
- DIM=3, DEPTH=4, `cmd_ready`=1, ack 5 cycles after each `start_sort`:
  - Beats are (cfg,0),(cfg,0),(start,0),(cfg,1),(cfg,1),(start,0),(cfg,2),(cfg,2),(start,0),(cfg,3),(cfg,0),(start,0).
  - Axis wraps to 0 at level 3. `done` pulses once. `busy` falls with it.
- `cmd_ready` low for 3 cycles on the axis beat → beat held stable for 4 cycles and accepted exactly once.
- No ack, TIMEOUT=16 → `error` pulses 16 cycles after the `start_sort` handshake. No `done`; state IDLE.
- In WAIT_ACK, `cmd_from_root`=switch_with_top with valid, then send_sort_ack → first ignored, second advances `level`.
- `rst` asserted during level-2 CFG_AXIS → next cycle all outputs at reset values. A following `start` restarts at level 0.
- `start` pulsed while `busy` → ignored, sequence unchanged. `start` in the `done` cycle → new pass begins next cycle.

Source files
------------

// File: rtl/kd_pkg.sv
// Shared kd-tree definitions: command encodings, scheduler states
// and the default command field width.
package kd_pkg;

    localparam int KD_CMD_W = 4;

    typedef enum logic [KD_CMD_W-1:0] {
        CMD_NOP         = 4'd0,
        CMD_START_SORT  = 4'd1,
        CMD_CFG_SORT    = 4'd2,
        CMD_WAIT_ACK    = 4'd3,
        CMD_SEND_ACK    = 4'd4,
        CMD_SWITCH_TOP  = 4'd5,
        CMD_SWITCH_DOWN = 4'd6
    } kd_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_TTL,
        S_CFG_AXIS,
        S_START,
        S_WAIT_ACK
    } sched_state_e;

endpackage

// File: rtl/kd_sort_sched_if.sv
// Root-node top-side command/data port.
// master: drives cmd/data/valid down, receives ready and upward commands.
// slave:  the root node side of the same port.
interface kd_sort_sched_if
    import kd_pkg::*;
#(
    parameter int CMD_W  = KD_CMD_W,
    parameter int DATA_W = 16
) ();

    logic [CMD_W-1:0]  cmd_to_root;
    logic [DATA_W-1:0] data_to_root;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_from_root;
    logic              cmd_from_root_valid;

    modport master (
        output cmd_to_root,
        output data_to_root,
        output cmd_valid,
        input  cmd_ready,
        input  cmd_from_root,
        input  cmd_from_root_valid
    );

    modport slave (
        input  cmd_to_root,
        input  data_to_root,
        input  cmd_valid,
        output cmd_ready,
        output cmd_from_root,
        output cmd_from_root_valid
    );

endinterface

// File: rtl/kd_sort_sched.sv
// Root-side kd-tree sort scheduler: per level sends configure_sort
// (ttl, axis) and start_sort, then waits for send_sort_ack with timeout.
// Ports: clk, rst (sync, high), start, busy, done, error, level,
// root (master side of the root command/data port).
module kd_sort_sched
    import kd_pkg::*;
#(
    parameter int DIM     = 3,
    parameter int DEPTH   = 4,
    parameter int CMD_W   = KD_CMD_W,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [$clog2(DEPTH):0] level,
    kd_sort_sched_if.master        root
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_e      state, state_n;
    logic [LW-1:0]     level_n;
    logic [AW-1:0]     axis, axis_n;
    logic [TW-1:0]     cnt, cnt_n;
    logic              done_n, error_n, valid_n;
    logic [CMD_W-1:0]  cmd_n;
    logic [DATA_W-1:0] data_n;
    logic              fire, ack, last, tmo;

    assign fire = root.cmd_valid && root.cmd_ready;
    assign ack  = root.cmd_from_root_valid &&
                  (root.cmd_from_root == CMD_W'(CMD_SEND_ACK));
    assign last = (level == LW'(DEPTH - 1));
    assign tmo  = (cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        level_n = level;
        axis_n  = axis;
        cnt_n   = cnt;
        done_n  = 1'b0;
        error_n = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    level_n = '0;
                    axis_n  = '0;
                    state_n = S_CFG_TTL;
                end
            end
            S_CFG_TTL: begin
                if (fire) state_n = S_CFG_AXIS;
            end
            S_CFG_AXIS: begin
                if (fire) state_n = S_START;
            end
            S_START: begin
                if (fire) begin
                    cnt_n   = '0;
                    state_n = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                cnt_n = cnt + 1'b1;
                // ack beats a simultaneous timeout
                if (ack) begin
                    if (last) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        level_n = level + 1'b1;
                        axis_n  = (axis == AW'(DIM - 1)) ?
                                  '0 : axis + 1'b1;
                        state_n = S_CFG_TTL;
                    end
                end else if (tmo) begin
                    error_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Beat outputs are decoded from the next state so they are
    // registered yet appear in the cycle the state is entered.
    always_comb begin
        valid_n = 1'b0;
        cmd_n   = CMD_W'(CMD_NOP);
        data_n  = '0;
        unique case (state_n)
            S_CFG_TTL: begin
                valid_n = 1'b1;
                cmd_n   = CMD_W'(CMD_CFG_SORT);
                data_n  = DATA_W'(level_n);
            end
            S_CFG_AXIS: begin
                valid_n = 1'b1;
                cmd_n   = CMD_W'(CMD_CFG_SORT);
                data_n  = DATA_W'(axis_n);
            end
            S_START: begin
                valid_n = 1'b1;
                cmd_n   = CMD_W'(CMD_START_SORT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            level             <= '0;
            axis              <= '0;
            cnt               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            root.cmd_valid    <= 1'b0;
            root.cmd_to_root  <= CMD_W'(CMD_NOP);
            root.data_to_root <= '0;
        end else begin
            state             <= state_n;
            level             <= level_n;
            axis              <= axis_n;
            cnt               <= cnt_n;
            busy              <= (state_n != S_IDLE);
            done              <= done_n;
            error             <= error_n;
            root.cmd_valid    <= valid_n;
            root.cmd_to_root  <= cmd_n;
            root.data_to_root <= data_n;
        end
    end

endmodule

// File: tb/tb_kd_sort_sched.sv
// Self-checking bench for kd_sort_sched: scoreboard of expected beats,
// backpressure, ignored upward commands, timeout, reset and restart.
module tb_kd_sort_sched;
    import kd_pkg::*;

    localparam int DIM     = 3;
    localparam int DEPTH   = 4;
    localparam int CMD_W   = 4;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, error;
    logic [2:0] level;
    logic       ready, auto_ack, ack_v, man_v;
    logic [3:0] man_cmd;
    int         ack_delay = 0;
    int         n_tests = 0, n_fail = 0, n_done = 0, n_err = 0;
    beat_t      exp_q[$];
    beat_t      mon_e;

    kd_sort_sched_if #(.CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

    kd_sort_sched #(
        .DIM(DIM), .DEPTH(DEPTH), .CMD_W(CMD_W),
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .done(done), .error(error), .level(level),
        .root(bus.master)
    );

    assign bus.cmd_ready           = ready;
    assign bus.cmd_from_root_valid = auto_ack ? ack_v : man_v;
    assign bus.cmd_from_root       = auto_ack ? CMD_W'(CMD_SEND_ACK) : man_cmd;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor and auto-ack responder (ack sampled 5 edges
    // after the start_sort handshake edge).
    initial ack_v = 1'b0;
    always @(negedge clk) begin
        if (ack_delay > 0) begin
            ack_delay = ack_delay - 1;
            ack_v = (ack_delay == 0);
        end else begin
            ack_v = 1'b0;
        end
        if (done)  n_done++;
        if (error) n_err++;
        if (bus.cmd_valid && bus.cmd_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL extra_beat got cmd=%0d data=%0d exp none",
                       bus.cmd_to_root, bus.data_to_root);
            end else begin
                mon_e = exp_q.pop_front();
                assert ({bus.cmd_to_root, bus.data_to_root} === mon_e)
                else begin
                    n_fail++;
                    $error("FAIL beat got cmd=%0d data=%0d exp cmd=%0d data=%0d",
                           bus.cmd_to_root, bus.data_to_root,
                           mon_e.cmd, mon_e.data);
                end
                if (bus.cmd_to_root == CMD_W'(CMD_START_SORT))
                    ack_delay = 5;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_valid"}, 32'(bus.cmd_valid), 0);
        chk({tag, "_cmd"},   32'(bus.cmd_to_root), 0);
        chk({tag, "_data"},  32'(bus.data_to_root), 0);
    endtask

    function automatic void push_levels(input int nlev);
        for (int l = 0; l < nlev; l++) begin
            exp_q.push_back(beat_t'{cmd: 4'd2, data: 16'(l)});
            exp_q.push_back(beat_t'{cmd: 4'd2, data: 16'(l % DIM)});
            exp_q.push_back(beat_t'{cmd: 4'd1, data: 16'd0});
        end
    endfunction

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
    endtask

    initial begin
        bit ok;
        int k;
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        auto_ack = 1'b1; man_v = 1'b0; man_cmd = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst0");
        @(posedge clk) #1 rst = 1'b0;

        // Pass 1: full sweep, with a start pulse while busy
        push_levels(DEPTH);
        start = 1'b1;
        @(negedge clk);
        chk("busy_before_start", 32'(busy), 0);
        @(posedge clk) #1 start = 1'b0;
        @(negedge clk);
        chk("busy_t1", 32'(busy), 1);
        chk("valid_t1", 32'(bus.cmd_valid), 1);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        wait_done(200, ok);
        chk("done1_seen", 32'(ok), 1);
        chk("busy_at_done", 32'(busy), 0);
        chk("level_at_done", 32'(level), 3);

        // Pass 2: start in the done cycle, backpressure on axis beat
        start = 1'b1;
        push_levels(DEPTH);
        @(posedge clk) #1 start = 1'b0;
        @(negedge clk);
        chk("p2_busy", 32'(busy), 1);
        chk("p2_level", 32'(level), 0);
        chk("p2_cmd", 32'(bus.cmd_to_root), 2);
        chk("done_is_pulse", 32'(done), 0);
        @(posedge clk) #1 ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.cmd_valid), 1);
            chk("hold_beat", {bus.cmd_to_root, bus.data_to_root}, {4'd2, 16'd0});
        end
        @(posedge clk) #1 ready = 1'b1;
        @(negedge clk);
        chk("hold_beat4", {bus.cmd_to_root, bus.data_to_root}, {4'd2, 16'd0});
        wait_done(300, ok);
        chk("done2_seen", 32'(ok), 1);
        @(negedge clk);
        chk("n_done_2", 32'(n_done), 2);

        // Pass 3: ignored upward command, then timeout on level 1
        auto_ack = 1'b0;
        push_levels(2);
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_valid && (bus.cmd_to_root == 4'd1);
        end
        chk("p3_start_beat", 32'(ok), 1);
        @(posedge clk) #1 begin man_v = 1'b1; man_cmd = 4'd5; end
        @(negedge clk);
        chk("wait_valid", 32'(bus.cmd_valid), 0);
        @(posedge clk) #1 man_cmd = 4'd4;
        @(negedge clk);
        chk("switch_ignored", 32'(level), 0);
        @(posedge clk) #1 begin man_v = 1'b0; man_cmd = 4'd0; end
        @(negedge clk);
        chk("ack_level", 32'(level), 1);
        chk("ack_beat", {bus.cmd_to_root, bus.data_to_root}, {4'd2, 16'd1});
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_valid && (bus.cmd_to_root == 4'd1);
        end
        chk("p3_start_beat1", 32'(ok), 1);
        // handshake edge H follows; error high from edge H+16
        k = 0; ok = 1'b0;
        while (k < 40 && !ok) begin
            @(negedge clk);
            k++;
            ok = error;
        end
        chk("error_seen", 32'(ok), 1);
        chk("error_latency", 32'(k), 17);
        chk("error_busy", 32'(busy), 0);
        chk("error_valid", 32'(bus.cmd_valid), 0);
        @(negedge clk);
        chk("error_pulse", 32'(error), 0);
        chk("n_err_1", 32'(n_err), 1);
        chk("no_done_on_err", 32'(n_done), 2);

        // Pass 4: reset during level-2 axis beat, then restart
        auto_ack = 1'b1;
        push_levels(2);
        exp_q.push_back(beat_t'{cmd: 4'd2, data: 16'd2});
        exp_q.push_back(beat_t'{cmd: 4'd2, data: 16'd2});
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        k = 0;
        while (k < 200 && exp_q.size() != 0) begin
            @(negedge clk);
            #1 k++;
        end
        chk("p4_reached_axis", 32'(exp_q.size()), 0);
        chk("p4_level2", 32'(level), 2);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        rst = 1'b0;
        push_levels(DEPTH);
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        @(negedge clk);
        chk("p4_restart_level", 32'(level), 0);
        chk("p4_restart_beat", {bus.cmd_to_root, bus.data_to_root}, {4'd2, 16'd0});
        wait_done(300, ok);
        chk("done4_seen", 32'(ok), 1);
        @(negedge clk);
        chk("n_done_3", 32'(n_done), 3);
        chk("n_err_final", 32'(n_err), 1);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
